bram_port_arbiter: RTL and testbench

//   Two-requester round-robin arbiter and sequencer for one single-port 16x1024 block RAM
//   (synchronous write, registered read, one access per cycle). Sits between two client

---
 rtl/bram_port_arbiter_pkg.sv | 22 ++
 rtl/bram_rd_tag_pipe.sv | 31 +++
 rtl/bram_port_arbiter.sv | 104 ++++++++++
 tb/tb_bram_port_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bram_port_arbiter_pkg.sv
// Shared widths, owner encodings and the read-tag type for the BRAM port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bram_port_arbiter_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int ADDR_W_DEF  = 10;
    localparam int MEM_LAT_DEF = 1;

    // Which client a returning read belongs to
    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

    // One in-flight read: valid bit plus owner
    typedef struct packed {
        logic   vld;
        owner_e own;
    } rd_tag_t;

endpackage

// File: rtl/bram_rd_tag_pipe.sv
// Shift register carrying {valid, owner} of issued reads until their RAM data returns.
// Latency: DEPTH cycles from tag_in to tag_out.
// Backpressure: none; advances every cycle, synchronous clear drops all in-flight tags.
module bram_rd_tag_pipe
    import bram_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t [DEPTH-1:0] stg;

    // Shift tags one stage per cycle; reset discards everything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            stg <= '0;
        end else begin
            stg[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    assign tag_out = stg[DEPTH-1];

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter/sequencer giving two clients (A, B) access to one single-port block RAM.
// Latency: grant is combinational; RAM port registered 1 cycle later; read data valid MEM_LAT+1 cycles after grant.
// Backpressure: a client holds req until gnt; the loser of a contended cycle waits, one command per cycle total.
module bram_port_arbiter
    import bram_port_arbiter_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_din,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_din,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    owner_e  last_grant;
    logic    a_win;
    logic    b_win;
    rd_tag_t tag_in;
    rd_tag_t tag_out;

    // Pick a winner: a sole requester always wins, on contention the one not granted last wins
    always_comb begin
        a_win = 1'b0;
        b_win = 1'b0;
        if (!rst) begin
            a_win = a_req && (!b_req || (last_grant == OWN_B));
            b_win = b_req && !a_win;
        end
    end

    assign a_gnt = a_win;
    assign b_gnt = b_win;

    // Remember the last granted client; starts as B so A wins the first contended cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= OWN_B;
        end else if (a_win) begin
            last_grant <= OWN_A;
        end else if (b_win) begin
            last_grant <= OWN_B;
        end
    end

    // Register the winning command onto the RAM port; idle cycles hold address/data to avoid toggling
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else if (a_win) begin
            mem_we   <= a_we;
            mem_addr <= a_addr;
            mem_din  <= a_din;
        end else if (b_win) begin
            mem_we   <= b_we;
            mem_addr <= b_addr;
            mem_din  <= b_din;
        end else begin
            mem_we   <= 1'b0;
        end
    end

    // Tag each granted read with its owner so the returning data can be steered
    always_comb begin
        tag_in     = '0;
        tag_in.vld = (a_win && !a_we) || (b_win && !b_we);
        tag_in.own = a_win ? OWN_A : OWN_B;
    end

    // One stage covers the issue register, MEM_LAT stages cover the RAM
    bram_rd_tag_pipe #(
        .DEPTH (MEM_LAT + 1)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign a_rvalid = tag_out.vld && (tag_out.own == OWN_A);
    assign b_rvalid = tag_out.vld && (tag_out.own == OWN_B);
    assign a_rdata  = mem_dout;
    assign b_rdata  = mem_dout;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a behavioural single-port RAM model.
// Latency: RAM model registers read data one cycle after mem_addr.
// Backpressure: clients hold req until granted.
module tb_bram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_we, b_req, b_we;
    logic [9:0]  a_addr, b_addr;
    logic [15:0] a_din, b_din;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [15:0] a_rdata, b_rdata;
    logic [9:0]  mem_addr;
    logic        mem_we;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;

    int tests = 0;
    int fails = 0;

    bram_port_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .a_req    (a_req),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_din    (a_din),
        .a_gnt    (a_gnt),
        .a_rvalid (a_rvalid),
        .a_rdata  (a_rdata),
        .b_req    (b_req),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .b_din    (b_din),
        .b_gnt    (b_gnt),
        .b_rvalid (b_rvalid),
        .b_rdata  (b_rdata),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    always #5 clk = ~clk;

    // Unwritten locations read back a recognisable address-derived pattern
    function automatic logic [15:0] ramval(input logic [9:0] a);
        return 16'hA000 | {6'd0, a};
    endfunction

    bit          wr_vld [0:1023];
    logic [15:0] wr_dat [0:1023];

    // RAM model: synchronous write, registered read (read-before-write)
    always @(posedge clk) begin
        if (mem_we) begin
            wr_vld[mem_addr] <= 1'b1;
            wr_dat[mem_addr] <= mem_din;
        end
        mem_dout <= wr_vld[mem_addr] ? wr_dat[mem_addr] : ramval(mem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [9:0] gaddr [0:9];
    bit         gown  [0:9];
    int         na, nb;
    bit         exp_a;

    initial begin
        rst = 1'b1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 10'h000; a_din = 16'h0000;
        b_req = 1'b1; b_we = 1'b0; b_addr = 10'h000; b_din = 16'h0000;

        // Reset held for 3 cycles with both clients requesting
        for (int i = 0; i < 3; i++) begin
            step();
            #2;
            chk("rst_a_gnt", a_gnt, 0);
            chk("rst_b_gnt", b_gnt, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_din", mem_din, 0);
            chk("rst_rvalid", {a_rvalid, b_rvalid}, 0);
        end
        step();
        rst = 1'b0;
        #2;
        chk("first_a_gnt", a_gnt, 1);
        chk("first_b_gnt", b_gnt, 0);
        step();
        a_req = 1'b0; b_req = 1'b0;
        #2;
        chk("first_idle_gnt", {a_gnt, b_gnt}, 0);
        step();
        #2;
        chk("first_a_rvalid", a_rvalid, 1);
        chk("first_a_rdata", a_rdata, 16'hA000);
        chk("first_b_rvalid", b_rvalid, 0);

        // A writes 0x005 <- 0xBEEF, then reads it back
        step();
        a_req = 1'b1; a_we = 1'b1; a_addr = 10'h005; a_din = 16'hBEEF;
        #2;
        chk("wr_a_gnt", a_gnt, 1);
        step();
        a_we = 1'b0; a_din = 16'h0000;
        #2;
        chk("rd_a_gnt", a_gnt, 1);
        chk("wr_mem_we", mem_we, 1);
        chk("wr_mem_addr", mem_addr, 10'h005);
        chk("wr_mem_din", mem_din, 16'hBEEF);
        step();
        a_req = 1'b0;
        #2;
        chk("wr_mem_we_pulse", mem_we, 0);
        chk("rd_early_rvalid", a_rvalid, 0);
        step();
        #2;
        chk("raw_a_rvalid", a_rvalid, 1);
        chk("raw_a_rdata", a_rdata, 16'hBEEF);
        chk("raw_b_rvalid", b_rvalid, 0);
        step();
        #2;
        chk("raw_rvalid_once", a_rvalid, 0);

        // Only B: three back-to-back reads at 0x100..0x102
        for (int i = 0; i < 6; i++) begin
            step();
            b_req = (i < 3); b_we = 1'b0; b_addr = 10'h100 + 10'(i);
            #2;
            chk("bonly_b_gnt", b_gnt, (i < 3) ? 1 : 0);
            chk("bonly_a_gnt", a_gnt, 0);
            chk("bonly_a_rvalid", a_rvalid, 0);
            if (i >= 2 && i < 5) begin
                chk("bonly_b_rvalid", b_rvalid, 1);
                chk("bonly_b_rdata", b_rdata, ramval(10'h100 + 10'(i - 2)));
            end else begin
                chk("bonly_b_rvalid_idle", b_rvalid, 0);
            end
        end

        // Both clients read continuously: strict A/B alternation, data steered to owner
        na = 0; nb = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            a_req = (k < 8); b_req = (k < 8); a_we = 1'b0; b_we = 1'b0;
            a_addr = 10'h010 + 10'(na);
            b_addr = 10'h200 + 10'(nb);
            #2;
            if (k < 8) begin
                exp_a = (k % 2 == 0);
                chk("alt_a_gnt", a_gnt, exp_a);
                chk("alt_b_gnt", b_gnt, !exp_a);
                gaddr[k] = exp_a ? a_addr : b_addr;
                gown[k]  = !exp_a;
                if (exp_a) na++; else nb++;
            end else begin
                chk("alt_drain_gnt", {a_gnt, b_gnt}, 0);
            end
            if (k >= 2) begin
                chk("alt_a_rvalid", a_rvalid, !gown[k-2]);
                chk("alt_b_rvalid", b_rvalid, gown[k-2]);
                chk("alt_rdata", gown[k-2] ? b_rdata : a_rdata, ramval(gaddr[k-2]));
            end else begin
                chk("alt_rvalid_early", {a_rvalid, b_rvalid}, 0);
            end
        end

        // A read granted, then reset next cycle: that read never returns
        step();
        a_req = 1'b1; a_we = 1'b0; a_addr = 10'h020; b_req = 1'b0;
        #2;
        chk("flush_a_gnt", a_gnt, 1);
        step();
        rst = 1'b1; b_req = 1'b1;
        #2;
        chk("flush_rst_gnt", {a_gnt, b_gnt}, 0);
        step();
        rst = 1'b0;
        #2;
        chk("flush_a_rvalid0", a_rvalid, 0);
        chk("flush_contend_a", a_gnt, 1);
        chk("flush_contend_b", b_gnt, 0);
        step();
        a_req = 1'b0; b_req = 1'b0;
        #2;
        chk("flush_a_rvalid1", a_rvalid, 0);
        step();
        #2;
        chk("post_rst_a_rvalid", a_rvalid, 1);
        chk("post_rst_a_rdata", a_rdata, ramval(10'h020));

        // Write 0x3FF <- 0x1234 then idle: RAM port must hold still
        step();
        a_req = 1'b1; a_we = 1'b1; a_addr = 10'h3FF; a_din = 16'h1234;
        #2;
        chk("hold_wr_gnt", a_gnt, 1);
        step();
        a_req = 1'b0; a_addr = 10'h0AA; a_din = 16'h5555;
        #2;
        chk("hold_wr_we", mem_we, 1);
        for (int i = 0; i < 10; i++) begin
            step();
            a_addr = 10'(i * 37); a_din = 16'(i * 16'h1111);
            #2;
            chk("hold_mem_we", mem_we, 0);
            chk("hold_mem_addr", mem_addr, 10'h3FF);
            chk("hold_mem_din", mem_din, 16'h1234);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
